// File: rtl/prbs_checker.sv
// Receive-side checker for the 32-bit Fibonacci LFSR stream: locks onto the
// sequence, then predicts every following word and counts mismatches.
module prbs_checker #(
    parameter int              N        = 32,
    parameter logic [N-1:0]    TAPS     = 32'h80200003,
    parameter int              LOCK_CNT = 4,
    parameter int              LOSS_CNT = 3,
    parameter int              ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_q,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      word_count,
    output logic             zero_flag,
    output logic             dbg_state
);

    // Handshake: in_q is consumed on every rising edge where in_valid is high;
    // there is no backpressure, the checker accepts one word per cycle.

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       prev, prev_nxt;
    logic [N-1:0]       pred, pred_nxt;
    logic               have_prev, have_prev_nxt;
    logic [3:0]         match_run, match_run_nxt;
    logic [3:0]         miss_run, miss_run_nxt;
    logic               pulse_nxt;
    logic               err_inc, word_inc, zero_det;
    logic [ERR_W-1:0]   err_base, err_nxt;
    logic [31:0]        word_base, word_nxt;
    logic               zero_nxt;

    function automatic logic [N-1:0] step(input logic [N-1:0] x);
        return {x[N-2:0], ^(x & TAPS)};
    endfunction

    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        pred_nxt      = pred;
        have_prev_nxt = have_prev;
        match_run_nxt = match_run;
        miss_run_nxt  = miss_run;
        pulse_nxt     = 1'b0;
        err_inc       = 1'b0;
        word_inc      = 1'b0;
        zero_det      = 1'b0;

        if (in_valid) begin
            zero_det = (in_q == '0);
            case (state)
                SEARCH: begin
                    prev_nxt      = in_q;
                    have_prev_nxt = 1'b1;
                    // A zero word never extends the run, so a stuck-at-zero source cannot lock.
                    if (have_prev && (in_q == step(prev)) && !zero_det)
                        match_run_nxt = match_run + 4'd1;
                    else
                        match_run_nxt = 4'd0;
                    if (match_run_nxt == 4'(LOCK_CNT)) begin
                        state_nxt     = LOCKED;
                        pred_nxt      = step(in_q);
                        miss_run_nxt  = 4'd0;
                        match_run_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    // Prediction free-runs from pred so one bad word costs exactly one error.
                    pred_nxt = step(pred);
                    word_inc = 1'b1;
                    if (in_q != pred) begin
                        pulse_nxt    = 1'b1;
                        err_inc      = 1'b1;
                        miss_run_nxt = miss_run + 4'd1;
                        if (miss_run_nxt == 4'(LOSS_CNT)) begin
                            state_nxt     = SEARCH;
                            match_run_nxt = 4'd0;
                            prev_nxt      = in_q;
                            have_prev_nxt = 1'b0;
                        end
                    end else begin
                        miss_run_nxt = 4'd0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end

        // clear zeroes the counters but this cycle's increment still lands.
        err_base  = clear ? '0 : err_count;
        err_nxt   = (err_inc && (err_base != '1)) ? err_base + 1'b1 : err_base;
        word_base = clear ? 32'd0 : word_count;
        word_nxt  = word_base + {31'd0, word_inc};
        zero_nxt  = (clear ? 1'b0 : zero_flag) | zero_det;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= SEARCH;
            prev       <= '0;
            pred       <= '0;
            have_prev  <= 1'b0;
            match_run  <= 4'd0;
            miss_run   <= 4'd0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= 32'd0;
            zero_flag  <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            pred       <= pred_nxt;
            have_prev  <= have_prev_nxt;
            match_run  <= match_run_nxt;
            miss_run   <= miss_run_nxt;
            err_pulse  <= pulse_nxt;
            err_count  <= err_nxt;
            word_count <= word_nxt;
            zero_flag  <= zero_nxt;
        end
    end

    assign locked    = (state == LOCKED);
    assign dbg_state = state;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, loss/relock, zero words,
// error-counter saturation (narrow second instance), gapped stream and reset.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_q = 32'd0;
    logic        clear = 1'b0;

    logic        locked, err_pulse, zero_flag, dbg_state;
    logic [15:0] err_count;
    logic [31:0] word_count;

    logic        s_locked, s_err_pulse, s_zero_flag, s_dbg_state;
    logic [3:0]  s_err_count;
    logic [31:0] s_word_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] gen;

    prbs_checker dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_q(in_q), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .word_count(word_count), .zero_flag(zero_flag), .dbg_state(dbg_state)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    prbs_checker #(.ERR_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_q(in_q), .clear(clear),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .word_count(s_word_count), .zero_flag(s_zero_flag), .dbg_state(s_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    task automatic cycle(input logic v, input logic [31:0] w);
        in_valid = v;
        in_q     = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_good();
        cycle(1'b1, gen);
        gen = lfsr_step(gen);
    endtask

    task automatic send_bad();
        cycle(1'b1, gen ^ 32'h1);
        gen = lfsr_step(gen);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle(1'b0, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle(1'b1, 32'h5);
        cycle(1'b1, 32'hB);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err: got %h want 0", err_count); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL reset_wc: got %h want 0", word_count); end
        checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero_flag); end
    endtask

    task automatic test_lock();
        reset_n = 1'b1;
        cycle(1'b1, 32'h1);
        cycle(1'b1, 32'h3);
        cycle(1'b1, 32'h6);
        cycle(1'b1, 32'hD);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
        cycle(1'b1, 32'h1B);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b want 1", locked); end
        checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL lock_state: got %b want 1", dbg_state); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL lock_err: got %h want 0", err_count); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL lock_wc0: got %h want 0", word_count); end
        cycle(1'b1, 32'h36);
        checks++; if (word_count !== 32'd1) begin errors++; $display("FAIL lock_wc1: got %h want 1", word_count); end
        gen = lfsr_step(32'h36);
    endtask

    task automatic test_single_error();
        send_good();
        send_good();
        cycle(1'b1, gen ^ 32'h80);
        gen = lfsr_step(gen);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err: got %h want 1", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b want 1", locked); end
        checks++; if (word_count !== 32'd4) begin errors++; $display("FAIL single_wc: got %h want 4", word_count); end
        send_good();
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_off: got %b want 0", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_hold: got %h want 1", err_count); end
        checks++; if (word_count !== 32'd5) begin errors++; $display("FAIL single_wc2: got %h want 5", word_count); end
    endtask

    task automatic test_loss_relock();
        cycle(1'b1, 32'hDEADBEEF);
        cycle(1'b1, 32'h12345678);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_hold: got %b want 1", locked); end
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL loss_err2: got %h want 3", err_count); end
        cycle(1'b1, 32'hCAFEF00D);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b want 0", locked); end
        checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL loss_err3: got %h want 4", err_count); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse: got %b want 1", err_pulse); end
        checks++; if (word_count !== 32'd8) begin errors++; $display("FAIL loss_wc: got %h want 8", word_count); end
        for (int i = 0; i < 4; i++) send_good();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked); end
        checks++; if (word_count !== 32'd8) begin errors++; $display("FAIL relock_wc: got %h want 8", word_count); end
        send_good();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked); end
        checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL relock_err: got %h want 4", err_count); end
    endtask

    task automatic test_zero();
        do_reset();
        cycle(1'b1, 32'd0);
        checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL zero_set: got %b want 1", zero_flag); end
        for (int i = 0; i < 19; i++) cycle(1'b1, 32'd0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_locked: got %b want 0", locked); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL zero_err: got %h want 0", err_count); end
        checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL zero_sticky: got %b want 1", zero_flag); end
        clear = 1'b1;
        cycle(1'b0, 32'd0);
        clear = 1'b0;
        checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL zero_clear: got %b want 0", zero_flag); end
        clear = 1'b1;
        cycle(1'b1, 32'd0);
        clear = 1'b0;
        checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL zero_clear_set: got %b want 1", zero_flag); end
    endtask

    task automatic test_saturation();
        do_reset();
        gen = 32'h1;
        for (int i = 0; i < 5; i++) send_good();
        checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_lock: got %b want 1", s_locked); end
        for (int i = 0; i < 7; i++) begin
            send_bad();
            send_bad();
            send_good();
        end
        checks++; if (s_err_count !== 4'd14) begin errors++; $display("FAIL sat_14: got %h want e", s_err_count); end
        checks++; if (err_count !== 16'd14) begin errors++; $display("FAIL sat_main14: got %h want e", err_count); end
        send_bad();
        checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_15: got %h want f", s_err_count); end
        send_bad();
        checks++; if (s_err_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse1: got %b want 1", s_err_pulse); end
        checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_hold1: got %h want f", s_err_count); end
        send_good();
        send_bad();
        checks++; if (s_err_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse2: got %b want 1", s_err_pulse); end
        checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_hold2: got %h want f", s_err_count); end
        checks++; if (err_count !== 16'd17) begin errors++; $display("FAIL sat_main17: got %h want 11", err_count); end
        checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", s_locked); end
        clear = 1'b1;
        send_good();
        clear = 1'b0;
        checks++; if (s_err_count !== 4'd0) begin errors++; $display("FAIL sat_clear: got %h want 0", s_err_count); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clear_err: got %h want 0", err_count); end
        checks++; if (word_count !== 32'd1) begin errors++; $display("FAIL clear_wc: got %h want 1", word_count); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL clear_pulse: got %b want 0", err_pulse); end
    endtask

    task automatic test_gaps_and_reset();
        do_reset();
        gen = 32'h1;
        for (int i = 0; i < 5; i++) begin
            send_good();
            cycle(1'b0, 32'hFFFF_FFFF);
            checks++; if (locked !== (i == 4)) begin errors++; $display("FAIL gap_lock%0d: got %b want %b", i, locked, (i == 4)); end
            checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL gap_pulse%0d: got %b want 0", i, err_pulse); end
        end
        send_good();
        send_bad();
        reset_n = 1'b0;
        send_good();
        reset_n = 1'b1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midreset_locked: got %b want 0", locked); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL midreset_err: got %h want 0", err_count); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL midreset_wc: got %h want 0", word_count); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL midreset_pulse: got %b want 0", err_pulse); end
        for (int i = 0; i < 4; i++) send_good();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL post_reset_first: got %b want 0", locked); end
        send_good();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_reset_lock: got %b want 1", locked); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_zero();
        test_saturation();
        test_gaps_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
